// File: rtl/mpdmac_engine.sv
// Matrix DMA datapath: copies a W x W matrix of 32-bit words src -> dst over a single-beat AXI4 master.
// Define MPDMAC_TRANSPOSE_EN to write the transpose into dst instead of a plain copy.
module mpdmac_engine #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WIDTH_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        src_addr_i,
  input  logic [31:0]        dst_addr_i,
  input  logic [WIDTH_W-1:0] mat_width_i,
  input  logic               start_i,
  output logic               done_o,
  output logic               err_o,
  output logic [31:0]        araddr_o,
  output logic               arvalid_o,
  input  logic               arready_i,
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [1:0]         rresp_i,
  input  logic               rvalid_i,
  output logic               rready_o,
  output logic [31:0]        awaddr_o,
  output logic               awvalid_o,
  input  logic               awready_i,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               wvalid_o,
  input  logic               wready_i,
  input  logic [1:0]         bresp_i,
  input  logic               bvalid_i,
  output logic               bready_o
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

  state_t             state;
  logic [WIDTH_W-1:0] w_q;
  logic [WIDTH_W-1:0] row;
  logic [WIDTH_W-1:0] col;
  logic [WIDTH_W-1:0] w_max;
  logic               col_last;
  logic               row_last;
  logic               aw_ok;
  logic               w_ok;

  assign w_max    = w_q - WIDTH_W'(1);
  assign col_last = (col == w_max);
  assign row_last = (row == w_max);
  // A channel is finished once its valid has dropped or is being accepted now
  assign aw_ok    = !awvalid_o || awready_i;
  assign w_ok     = !wvalid_o || wready_i;

`ifdef MPDMAC_TRANSPOSE_EN
  // Write pointer walks down a dst column; row_base tracks dst + 4*row
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] stride;
  assign stride = ADDR_W'({w_q, 2'b00});
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      row       <= '0;
      col       <= '0;
      done_o    <= 1'b1;
      err_o     <= 1'b0;
      araddr_o  <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awaddr_o  <= '0;
      awvalid_o <= 1'b0;
      wdata_o   <= '0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
`ifdef MPDMAC_TRANSPOSE_EN
      row_base  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            err_o <= 1'b0;
            if (mat_width_i != '0) begin
              w_q       <= mat_width_i;
              row       <= '0;
              col       <= '0;
              araddr_o  <= src_addr_i;
              awaddr_o  <= dst_addr_i;
`ifdef MPDMAC_TRANSPOSE_EN
              row_base  <= dst_addr_i;
`endif
              done_o    <= 1'b0;
              arvalid_o <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            wdata_o   <= rdata_i;
            if (rresp_i != 2'b00) err_o <= 1'b1;
            rready_o  <= 1'b0;
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            state     <= WR;
          end
        end
        WR: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            if (bresp_i != 2'b00) err_o <= 1'b1;
            if (col_last && row_last) begin
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              araddr_o  <= araddr_o + WORD_BYTES;
              arvalid_o <= 1'b1;
              state     <= RD_ADDR;
              if (col_last) begin
                col <= '0;
                row <= row + WIDTH_W'(1);
              end else begin
                col <= col + WIDTH_W'(1);
              end
`ifdef MPDMAC_TRANSPOSE_EN
              if (col_last) begin
                row_base <= row_base + WORD_BYTES;
                awaddr_o <= row_base + WORD_BYTES;
              end else begin
                awaddr_o <= awaddr_o + stride;
              end
`else
              awaddr_o <= awaddr_o + WORD_BYTES;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpdmac_engine.sv
// Self-checking bench for mpdmac_engine: reactive AXI slave with memory, scoreboard of expected AR/write traffic.
module tb_mpdmac_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [5:0]  mat_width_i;
  logic        start_i;
  logic        done_o, err_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic        wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;

  always #5 clk = ~clk;

  mpdmac_engine #(.DATA_W(32), .WIDTH_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .mat_width_i(mat_width_i), .start_i(start_i),
    .done_o(done_o), .err_o(err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;

  wr_t         exp_wr_q[$], obs_wr_q[$];
  logic [31:0] exp_ar_q[$], obs_ar_q[$];
  logic [31:0] mem [logic [31:0]];
  int n_cmp = 0, n_bad = 0;

  // slave model state
  bit          stall_en = 0;
  int          err_rd_idx = -1;
  int          rd_count = 0, b_count = 0, stab_viol = 0;
  bit          rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] rd_addr, aw_a, w_d;
  bit          ar_hold = 0, aw_hold = 0, w_hold = 0;
  logic [31:0] ar_hold_a, aw_hold_a, w_hold_d;

  function automatic int rnd();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Handshake monitor: records traffic and checks valid/payload stability under stall
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      ar_hold = 0; aw_hold = 0; w_hold = 0;
    end else begin
      if (ar_hold && (!arvalid_o || araddr_o !== ar_hold_a)) stab_viol++;
      if (aw_hold && (!awvalid_o || awaddr_o !== aw_hold_a)) stab_viol++;
      if (w_hold && (!wvalid_o || wdata_o !== w_hold_d)) stab_viol++;
      ar_hold = arvalid_o && !arready_i; ar_hold_a = araddr_o;
      aw_hold = awvalid_o && !awready_i; aw_hold_a = awaddr_o;
      w_hold  = wvalid_o && !wready_i;   w_hold_d = wdata_o;
      if (bvalid_i && bready_o) begin b_pend = 0; b_count++; end
      if (rvalid_i && rready_o) begin rd_pend = 0; rd_count++; end
      if (arvalid_o && arready_i) begin
        obs_ar_q.push_back(araddr_o);
        rd_pend = 1; rd_addr = araddr_o; r_wait = rnd(); ar_wait = rnd();
      end
      if (awvalid_o && awready_i) begin aw_got = 1; aw_a = awaddr_o; aw_wait = rnd(); end
      if (wvalid_o && wready_i) begin w_got = 1; w_d = wdata_o; w_wait = rnd(); end
      if (aw_got && w_got) begin
        mem[aw_a] = w_d;
        obs_wr_q.push_back('{aw_a, w_d});
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = rnd();
      end
    end
  end

  // Slave driver: updates ready/valid on the falling edge
  always @(negedge clk) begin
    arready_i = 1'b0;
    if (arvalid_o) begin if (ar_wait == 0) arready_i = 1'b1; else ar_wait--; end
    rvalid_i = 1'b0;
    if (rd_pend) begin
      if (r_wait == 0) begin
        rvalid_i = 1'b1;
        rdata_i  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
        rresp_i  = (rd_count == err_rd_idx) ? 2'b10 : 2'b00;
      end else r_wait--;
    end
    awready_i = 1'b0;
    if (awvalid_o && !aw_got) begin if (aw_wait == 0) awready_i = 1'b1; else aw_wait--; end
    wready_i = 1'b0;
    if (wvalid_o && !w_got) begin if (w_wait == 0) wready_i = 1'b1; else w_wait--; end
    bvalid_i = 1'b0;
    bresp_i  = 2'b00;
    if (b_pend) begin if (b_wait == 0) bvalid_i = 1'b1; else b_wait--; end
  end

  task automatic fill_src(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
  endtask

  // Expected traffic is queued as the copy is launched
  task automatic push_expected(input logic [31:0] s, input logic [31:0] d, input int w);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++) begin
        logic [31:0] sa, wa;
        sa = s + 32'(4 * (r * w + c));
`ifdef MPDMAC_TRANSPOSE_EN
        wa = d + 32'(4 * (c * w + r));
`else
        wa = d + 32'(4 * (r * w + c));
`endif
        exp_ar_q.push_back(sa);
        exp_wr_q.push_back('{wa, mem[sa]});
      end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [5:0] w);
    @(negedge clk);
    src_addr_i = s; dst_addr_i = d; mat_width_i = w; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0; to = 0;
    while (done_o == 1'b0 && !to) begin
      cyc++;
      @(negedge clk);
      if (cyc > 5000) to = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({done_o, err_o} !== 2'b10) begin
      n_bad++; $display("FAIL reset_done_err got %b want 10", {done_o, err_o});
    end
    n_cmp++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids got %b want 00000", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o});
    end
    n_cmp++;
    if ({araddr_o, awaddr_o, wdata_o} !== 96'h0) begin
      n_bad++; $display("FAIL reset_addr_data got %h %h %h want 0", araddr_o, awaddr_o, wdata_o);
    end
  endtask

  task automatic test_basic();
    int cyc; bit to;
    logic [31:0] a[4];
    logic [31:0] want;
    a[0] = 32'hA0A0_0001; a[1] = 32'hB0B0_0002; a[2] = 32'hC0C0_0003; a[3] = 32'hD0D0_0004;
    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = a[i];
    push_expected(32'h1000, 32'h2000, 2);
    start_copy(32'h1000, 32'h2000, 6'd2);
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc != 16) begin n_bad++; $display("FAIL basic_busy_cycles got %0d (timeout %0d) want 16", cyc, to); end
    n_cmp++;
    if (obs_ar_q.size() != exp_ar_q.size()) begin
      n_bad++; $display("FAIL basic_ar_count got %0d want %0d", obs_ar_q.size(), exp_ar_q.size());
    end
    while (exp_ar_q.size() > 0 && obs_ar_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_ar_q.pop_front(); o = obs_ar_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_ar_addr got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      n_bad++; $display("FAIL basic_wr_count got %0d want %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL basic_wr got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
`ifdef MPDMAC_TRANSPOSE_EN
    want = a[2];
`else
    want = a[1];
`endif
    n_cmp++;
    if (mem[32'h2004] !== want) begin n_bad++; $display("FAIL basic_dst1 got %h want %h", mem[32'h2004], want); end
    n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", err_o); end
  endtask

  task automatic test_rresp_error();
    int cyc, k, base; bit to;
    fill_src(32'h3000, 4);
    push_expected(32'h3000, 32'h3800, 2);
    base = rd_count;
    err_rd_idx = base + 1;
    start_copy(32'h3000, 32'h3800, 6'd2);
    k = 0;
    while (rd_count < base + 2 && k < 200) begin k++; @(negedge clk); end
    n_cmp++;
    if (k >= 200 || err_o !== 1'b1) begin n_bad++; $display("FAIL err_after_beat got %b (wait %0d) want 1", err_o, k); end
    wait_done(cyc, to);
    err_rd_idx = -1;
    n_cmp++;
    if (to || err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b (timeout %0d) want 1", err_o, to); end
    n_cmp++;
    if (obs_wr_q.size() != 4) begin n_bad++; $display("FAIL err_wr_count got %0d want 4", obs_wr_q.size()); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL err_wr got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_ar_q.delete(); obs_ar_q.delete(); exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_zero_width();
    bit saw_bus = 0, saw_busy = 0;
    start_copy(32'h4000, 32'h4800, 6'd0);
    n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL zero_err_clear got %b want 0", err_o); end
    for (int i = 0; i < 20; i++) begin
      if (arvalid_o || awvalid_o || wvalid_o) saw_bus = 1;
      if (!done_o) saw_busy = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_bus || saw_busy) begin n_bad++; $display("FAIL zero_idle got bus=%0d busy=%0d want 0 0", saw_bus, saw_busy); end
  endtask

  task automatic test_stall();
    int cyc, bbase; bit to;
    stall_en = 1;
    ar_wait = rnd(); aw_wait = rnd(); w_wait = rnd();
    stab_viol = 0;
    bbase = b_count;
    fill_src(32'h6000, 9);
    push_expected(32'h6000, 32'h7000, 3);
    start_copy(32'h6000, 32'h7000, 6'd3);
    wait_done(cyc, to);
    stall_en = 0;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL stall_timeout got %0d cycles want completion", cyc); end
    n_cmp++;
    if (stab_viol != 0) begin n_bad++; $display("FAIL stall_stable got %0d violations want 0", stab_viol); end
    n_cmp++;
    if (b_count - bbase != 9) begin n_bad++; $display("FAIL stall_b_count got %0d want 9", b_count - bbase); end
    n_cmp++;
    if (obs_ar_q.size() != 9 || obs_wr_q.size() != 9) begin
      n_bad++; $display("FAIL stall_counts got ar=%0d wr=%0d want 9 9", obs_ar_q.size(), obs_wr_q.size());
    end
    while (exp_ar_q.size() > 0 && obs_ar_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_ar_q.pop_front(); o = obs_ar_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL stall_ar_addr got %h want %h", o, e); end
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL stall_wr got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_ar_q.delete(); obs_ar_q.delete(); exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_restart_ignored();
    int cyc, rises = 0; bit to, prev;
    fill_src(32'h8000, 16);
    push_expected(32'h8000, 32'h8800, 4);
    start_copy(32'h8000, 32'h8800, 6'd4);
    for (int p = 0; p < 2; p++) begin
      repeat (13) @(negedge clk);
      src_addr_i = 32'h9000; dst_addr_i = 32'h9800; mat_width_i = 6'd2; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(cyc, to);
    prev = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_o && !prev) rises++;
      if (!done_o) rises += 10;
      prev = done_o;
    end
    n_cmp++;
    if (to || rises != 0) begin n_bad++; $display("FAIL restart_done got timeout=%0d extra=%0d want 0 0", to, rises); end
    n_cmp++;
    if (obs_ar_q.size() != 16 || obs_wr_q.size() != 16) begin
      n_bad++; $display("FAIL restart_counts got ar=%0d wr=%0d want 16 16", obs_ar_q.size(), obs_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL restart_wr got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_ar_q.delete(); obs_ar_q.delete(); exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc, k, bbase; bit to;
    fill_src(32'hA000, 4);
    start_copy(32'hA000, 32'hA800, 6'd2);
    k = 0;
    while (!awvalid_o && k < 100) begin k++; @(negedge clk); end
    n_cmp++;
    if (k >= 100) begin n_bad++; $display("FAIL rstmid_reach_wr got timeout want awvalid"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, done_o} !== 6'b000001) begin
      n_bad++; $display("FAIL rstmid_outputs got %b want 000001", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, done_o});
    end
    rst_n = 1'b1;
    exp_ar_q.delete(); obs_ar_q.delete(); exp_wr_q.delete(); obs_wr_q.delete();
    fill_src(32'hB000, 1);
    push_expected(32'hB000, 32'hB800, 1);
    bbase = b_count;
    start_copy(32'hB000, 32'hB800, 6'd1);
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc != 4) begin n_bad++; $display("FAIL rstmid_w1_cycles got %0d want 4", cyc); end
    n_cmp++;
    if (obs_wr_q.size() != 1 || b_count - bbase != 1) begin
      n_bad++; $display("FAIL rstmid_w1_count got wr=%0d b=%0d want 1 1", obs_wr_q.size(), b_count - bbase);
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL rstmid_wr got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; mat_width_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    test_reset();
    test_basic();
    test_rresp_error();
    test_zero_width();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
